// File: rtl/mealy_fsm_pkg.sv
// Shared types and default configuration for the serial "01" Mealy pattern detector.
package mealy_fsm_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_GOT0 = 1'b1
    } state_t;

    localparam int         DEFAULT_PATTERN_W = 2;
    localparam logic [1:0] DEFAULT_PATTERN   = 2'b01;

endpackage

// File: rtl/mealy_fsm.sv
// Mealy serial pattern detector: out flags a match in the same cycle the final
// pattern bit is present on in_bit; history and fill count are registered.
module mealy_fsm
    import mealy_fsm_pkg::*;
#(
    parameter int                   PATTERN_W = DEFAULT_PATTERN_W,
    parameter logic [PATTERN_W-1:0] PATTERN   = DEFAULT_PATTERN
) (
    input  logic clk,
    input  logic reset,
    input  logic in_bit,
    output logic out
);

    // The default "01" detector collapses to a two-state machine; other patterns
    // use the general history shift register plus a saturating fill counter.
    localparam bit USE_FSM = (PATTERN_W == 2) && PATTERN[0] && !PATTERN[PATTERN_W-1];

    generate
        if (USE_FSM) begin : g_fsm
            state_t r_state;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_state <= S_IDLE;
                end else begin
                    r_state <= in_bit ? S_IDLE : S_GOT0;
                end
            end

            assign out = !reset && (r_state == S_GOT0) && in_bit;
        end else begin : g_generic
            localparam int             FW       = (PATTERN_W > 2) ? $clog2(PATTERN_W) : 1;
            localparam logic [FW-1:0]  FILL_MAX = FW'(PATTERN_W - 1);

            logic [PATTERN_W-2:0] r_hist;
            logic [PATTERN_W-2:0] w_histNext;
            logic [FW-1:0]        r_fill;

            if (PATTERN_W == 2) begin : g_hist1
                assign w_histNext = in_bit;
            end else begin : g_histN
                assign w_histNext = {r_hist[PATTERN_W-3:0], in_bit};
            end

            // No match is possible until PATTERN_W-1 bits have been seen since reset.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_hist <= '0;
                    r_fill <= '0;
                end else begin
                    r_hist <= w_histNext;
                    if (r_fill != FILL_MAX) begin
                        r_fill <= r_fill + 1'b1;
                    end
                end
            end

            assign out = !reset && (r_fill == FILL_MAX) && ({r_hist, in_bit} == PATTERN);
        end
    endgenerate

endmodule

// File: tb/tb_mealy_fsm.sv
// Self-checking bench for mealy_fsm: default "01" build plus a 3-bit "101" build,
// directed scenarios and randomized traffic against a sequence-level model.
module tb_mealy_fsm;

    logic clk;
    logic reset;
    logic in_bit;
    logic in3;
    logic out;
    logic out3;

    int errors = 0;
    int checks = 0;

    // Model state: number of bits sampled since reset and recent bits (newest LSB)
    int seen0 = 0, recent0 = 0;
    int seen3 = 0, recent3 = 0;

    logic obs0, obs3, exp0, exp3;

    mealy_fsm dut (
        .clk    (clk),
        .reset  (reset),
        .in_bit (in_bit),
        .out    (out)
    );

    mealy_fsm #(.PATTERN_W(3), .PATTERN(3'b101)) dut3 (
        .clk    (clk),
        .reset  (reset),
        .in_bit (in3),
        .out    (out3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A match needs PATTERN_W-1 earlier bits since reset; the last W bits,
    // oldest first, including the present bit, must equal the pattern.
    function automatic logic modelOut(int w, int pat, int seen, int recent, logic rst, logic cur);
        int window;
        if (rst) return 1'b0;
        if (seen < w - 1) return 1'b0;
        window = (recent * 2 + int'(cur)) % (1 << w);
        return (window == pat);
    endfunction

    // Drive one cycle on both DUTs, sample mid-cycle, then advance the model.
    task automatic applyStimulus(input logic rst, input logic b, input logic b3);
        @(negedge clk);
        reset  = rst;
        in_bit = b;
        in3    = b3;
        #1;
        obs0 = out;
        obs3 = out3;
        exp0 = modelOut(2, 1, seen0, recent0, rst, b);
        exp3 = modelOut(3, 5, seen3, recent3, rst, b3);
        @(posedge clk);
        if (rst) begin
            seen0 = 0; recent0 = 0;
            seen3 = 0; recent3 = 0;
        end else begin
            seen0++; recent0 = (recent0 * 2 + int'(b))  % 256;
            seen3++; recent3 = (recent3 * 2 + int'(b3)) % 256;
        end
    endtask

    task automatic test_reset();
        applyStimulus(1'b1, 1'b0, 1'b0);
        checks++;
        if (obs0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out out=%b expected=0", obs0);
        end
        applyStimulus(1'b0, 1'b1, 1'b1);
        checks++;
        if (obs0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL first_one_after_reset out=%b expected=0", obs0);
        end
        checks++;
        if (obs3 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL w3_first_one_after_reset out=%b expected=0", obs3);
        end
    endtask

    task automatic test_sequence();
        logic [7:0] bits = 8'b0101_1001;
        logic [7:0] want = 8'b0101_0001;
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(1'b0, bits[i], 1'b0);
            checks++;
            if (obs0 !== want[i]) begin
                errors++;
                $display("[TB] FAIL sequence[%0d] out=%b expected=%b", 7 - i, obs0, want[i]);
            end
        end
    endtask

    task automatic test_sameCycle();
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_bit = 1'b0;
        #1;
        checks++;
        if (out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL same_cycle_low out=%b expected=0", out);
        end
        #1;
        in_bit = 1'b1;
        #1;
        checks++;
        if (out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL same_cycle_rise out=%b expected=1", out);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL same_cycle_after_edge out=%b expected=0", out);
        end
        seen0 = 2; recent0 = 1; seen3 = 2; recent3 = 0;
    endtask

    task automatic test_zeros();
        logic [4:0] want = 5'b00001;
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 4; i >= 0; i--) begin
            applyStimulus(1'b0, (i == 0), 1'b0);
            checks++;
            if (obs0 !== want[i]) begin
                errors++;
                $display("[TB] FAIL zeros[%0d] out=%b expected=%b", 4 - i, obs0, want[i]);
            end
        end
    endtask

    task automatic test_midReset();
        logic [3:0] want = 4'b0001;
        logic [3:0] bits = 4'b1101;
        logic [3:0] rsts = 4'b1000;
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int i = 3; i >= 0; i--) begin
            applyStimulus(rsts[i], bits[i], 1'b0);
            checks++;
            if (obs0 !== want[i]) begin
                errors++;
                $display("[TB] FAIL mid_reset[%0d] out=%b expected=%b", 3 - i, obs0, want[i]);
            end
        end
    endtask

    task automatic test_param();
        logic [4:0] bits = 5'b10101;
        logic [4:0] want = 5'b00101;
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 4; i >= 0; i--) begin
            applyStimulus(1'b0, 1'b0, bits[i]);
            checks++;
            if (obs3 !== want[i]) begin
                errors++;
                $display("[TB] FAIL w3_seq[%0d] out=%b expected=%b", 4 - i, obs3, want[i]);
            end
        end
    endtask

    task automatic test_random();
        logic rst, b, b3;
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 24) == 0);
            b   = 1'($urandom_range(0, 1));
            b3  = 1'($urandom_range(0, 1));
            applyStimulus(rst, b, b3);
            checks++;
            if (obs0 !== exp0) begin
                errors++;
                $display("[TB] FAIL random_w2[%0d] out=%b expected=%b", n, obs0, exp0);
            end
            checks++;
            if (obs3 !== exp3) begin
                errors++;
                $display("[TB] FAIL random_w3[%0d] out=%b expected=%b", n, obs3, exp3);
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        in_bit = 1'b0;
        in3    = 1'b0;
        $display("[TB] starting mealy_fsm bench");
        test_reset();
        test_sequence();
        test_sameCycle();
        test_zeros();
        test_midReset();
        test_param();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mealy_fsm.md
Name: mealy_fsm

Overview:
- Serial bit-pattern detector built as a Mealy machine. It samples one input bit per clock.
- Its output is combinational from the registered history and the current input bit. The output asserts in the same cycle that the final pattern bit is present on in_bit.
- The default configuration detects the two-bit sequence "01" with overlap allowed. It sits on a serial data path as a single-cycle match flag for downstream control.

Parameters:
- PATTERN_W, 2, pattern length in bits (>=2).
- PATTERN, 2'b01, pattern to detect. The MSB is the oldest bit and the LSB is the bit that completes the match.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset; single clock domain.
- in_bit  input  1  serial data bit, sampled at each rising edge of clk.
- out  output  1  Mealy match flag, combinational within the current cycle.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- State held in registers:
  - hist[PATTERN_W-2:0], the previously sampled bits, newest in the LSB.
  - fill count, 0..PATTERN_W-1, saturating.
- Reset (reset=1 at a rising edge): hist <= 0 and fill <= 0.
- out is forced to 0 combinationally whenever reset=1.
- Each rising edge with reset=0:
  - hist <= {hist[PATTERN_W-3:0], in_bit}; for PATTERN_W=2, hist <= in_bit.
  - fill <= min(fill+1, PATTERN_W-1).
- out = !reset && (fill == PATTERN_W-1) && ({hist, in_bit} == PATTERN).
  - There is no latency register: out follows in_bit within the same cycle.
  - out may glitch while in_bit settles; consumers sample it at the clock edge.
- Default (PATTERN="01") reduces to two states:
  - S_IDLE: reset state, or last sampled bit was 1.
    - in_bit=0 -> S_GOT0, out=0.
    - in_bit=1 -> S_IDLE, out=0.
  - S_GOT0: last sampled bit was 0.
    - in_bit=0 -> S_GOT0, out=0.
    - in_bit=1 -> S_IDLE, out=1.
- Overlap: matches may overlap. For "01", "0101" yields two matches.
- Boundary conditions:
  - A 1 on the first sampled bit after reset never matches, because fill is not yet full.
  - Consecutive 1s ("011"): only the first 1 asserts out.
  - Runs of 0s keep the machine in S_GOT0 with out=0.
  - Reset mid-sequence discards history. The next match requires a full PATTERN_W bits after reset deasserts.
  - Reset has priority over in_bit in the same cycle.
- No X propagation: all registers are reset; out is never X after the first reset edge.

Decomposition:
- Shared package mealy_fsm_pkg holds:
  - state enum (S_IDLE, S_GOT0) for the default build;
  - default PATTERN/PATTERN_W constants.
- No sub-module. A history shift register plus a comparator is kept inline.

Test Plan:
- Reset: reset=1 for 1 cycle with in_bit=0 -> out=0 throughout; state S_IDLE. Deassert, then in_bit=1 -> out=0 (no prior 0).
- Bit-per-cycle sequence 0,1,0,1,1,0,0,1 after reset -> out per cycle: 0,1,0,1,0,0,0,1.
- Same-cycle response: in S_GOT0, drive in_bit 0->1 mid-cycle -> out rises in the same cycle, before the next edge. It returns to 0 after that edge if in_bit stays 1.
- Run of zeros: 0,0,0,0,1 -> out=1 only on the final cycle.
- Reset mid-operation: after sampling 0, assert reset with in_bit=1 -> out=0. Release, then drive 1 -> out=0. Then drive 0,1 -> out=1 on the 1.
- Parameter build: PATTERN_W=3, PATTERN=3'b101, input 1,0,1,0,1 -> out: 0,0,1,0,1.
